// File: rtl/uart_rx_fifo_if.sv
// CPU-side read path of the UART receiver: head byte, occupancy and sticky status,
// plus the pop / clear-error strobes driven by the bus decoder.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 3
);
  logic                     i_pop;
  logic                     i_clr_err;
  logic [7:0]               o_data;
  logic                     o_valid;
  logic [FIFO_DEPTH_LOG2:0] o_count;
  logic                     o_overrun;
  logic                     o_frame_err;
  logic                     o_busy;

  modport master (
    output i_pop, i_clr_err,
    input  o_data, o_valid, o_count, o_overrun, o_frame_err, o_busy
  );

  modport slave (
    input  i_pop, i_clr_err,
    output o_data, o_valid, o_count, o_overrun, o_frame_err, o_busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle-high) feeding a small show-ahead FIFO
// that the CPU drains through the UART window.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | half-bit wait, then re-check start bit (high = glitch)
// S_DATA  | eight full-bit waits, each samples one data bit, LSB first
// S_STOP  | full-bit wait, then sample stop bit; high pushes the byte
// S_BREAK | stop bit was low; hold until the line returns high
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic             i_clk_50mhz,
  input  logic             i_reset_n,
  input  logic             i_rx,
  uart_rx_fifo_if.slave    bus
);

  localparam int          DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        busy;
  logic        frame_err;
  logic        rx_m;
  logic        rx_s;

  logic [7:0]               mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic                     overrun;

  logic push_req;
  logic pop_req;
  logic do_push;
  logic full;
  logic empty;
  logic tc;

  // i_rx is asynchronous; only rx_s may be used for decisions.
  always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  assign tc       = (clk_cnt == 16'd0);
  assign push_req = (state == S_STOP) && tc && rx_s;

  always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      clk_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (bus.i_clr_err) begin
        frame_err <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (!rx_s) begin
            clk_cnt <= HALF_TC;
            state   <= S_START;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (tc) begin
            if (!rx_s) begin
              clk_cnt <= BIT_TC;
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (tc) begin
            shift[bit_idx] <= rx_s;
            clk_cnt        <= BIT_TC;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (tc) begin
            if (rx_s) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              // Set after the clear above so a same-edge set wins.
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt - 16'd1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                   (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
  assign pop_req = bus.i_pop && !empty;
  // A pop on the same edge frees the slot the incoming byte needs.
  assign do_push = push_req && (!full || pop_req);

  always_ff @(posedge i_clk_50mhz) begin
    if (do_push) begin
      mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= shift;
    end
  end

  always_ff @(posedge i_clk_50mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_req) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop_req})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop_req) begin
        overrun <= 1'b1;
      end else if (bus.i_clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.o_data      = empty ? 8'h00 : mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
  assign bus.o_valid     = !empty;
  assign bus.o_count     = count;
  assign bus.o_overrun   = overrun;
  assign bus.o_frame_err = frame_err;
  assign bus.o_busy      = busy;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames are driven on i_rx, the bytes
// expected to reach the FIFO are queued, and each pop is compared against the queue.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int DL  = 3;
  // First posedge after the start-bit negedge is edge 1; the stop bit is sampled on this edge.
  localparam int PUSH_EDGE = 155;

  logic i_clk_50mhz = 1'b0;
  logic i_reset_n   = 1'b0;
  logic i_rx        = 1'b1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb [$];

  always #5 i_clk_50mhz = ~i_clk_50mhz;

  uart_rx_fifo_if #(.FIFO_DEPTH_LOG2(DL)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (DL)
  ) dut (
    .i_clk_50mhz (i_clk_50mhz),
    .i_reset_n   (i_reset_n),
    .i_rx        (i_rx),
    .bus         (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; drives a full frame, optionally holding the stop bit low.
  task automatic send_byte(input logic [7:0] d, input int stop_low_bits);
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk_50mhz);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (CPB) @(negedge i_clk_50mhz);
    end
    if (stop_low_bits > 0) begin
      i_rx = 1'b0;
      repeat (stop_low_bits * CPB) @(negedge i_clk_50mhz);
    end
    i_rx = 1'b1;
    repeat (CPB) @(negedge i_clk_50mhz);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int k = 0;
    while (bus.o_busy && k < max_cycles) begin
      @(negedge i_clk_50mhz);
      k++;
    end
    chk({tag, "_idle"}, bus.o_busy, 1'b0);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    chk({tag, "_valid"}, bus.o_valid, 1'b1);
    chk({tag, "_sb"}, (sb.size() > 0), 1'b1);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    chk({tag, "_data"}, bus.o_data, exp);
    bus.i_pop = 1'b1;
    @(negedge i_clk_50mhz);
    bus.i_pop = 1'b0;
  endtask

  // Sends d while holding i_pop across exactly the edge that pushes d.
  task automatic send_pop_at_push(input string tag, input logic [7:0] d, input logic head_expected);
    sb.push_back(d);
    fork
      send_byte(d, 0);
      begin
        logic [7:0] exp;
        repeat (PUSH_EDGE - 1) @(posedge i_clk_50mhz);
        @(negedge i_clk_50mhz);
        chk({tag, "_head"}, bus.o_valid, head_expected);
        if (head_expected) begin
          exp = sb.pop_front();
          chk({tag, "_hdata"}, bus.o_data, exp);
        end
        bus.i_pop = 1'b1;
        @(negedge i_clk_50mhz);
        bus.i_pop = 1'b0;
      end
    join
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.o_valid, 1'b0);
    chk({tag, "_count"}, bus.o_count, '0);
    chk({tag, "_data"}, bus.o_data, 8'h00);
    chk({tag, "_ovr"}, bus.o_overrun, 1'b0);
    chk({tag, "_ferr"}, bus.o_frame_err, 1'b0);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_pop     = 1'b0;
    bus.i_clr_err = 1'b0;
    repeat (3) @(negedge i_clk_50mhz);
    chk_all_zero("rst");
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk_50mhz);
    chk("rst_rel_busy", bus.o_busy, 1'b0);

    // single byte
    sb.push_back(8'h55);
    send_byte(8'h55, 0);
    wait_idle("single", 50);
    chk("single_count", bus.o_count, 4'd1);
    chk("single_ovr", bus.o_overrun, 1'b0);
    chk("single_ferr", bus.o_frame_err, 1'b0);
    pop_chk("single");
    chk("single_valid0", bus.o_valid, 1'b0);
    chk("single_count0", bus.o_count, 4'd0);

    // pop while empty
    bus.i_pop = 1'b1;
    @(negedge i_clk_50mhz);
    bus.i_pop = 1'b0;
    chk("pop_empty_count", bus.o_count, 4'd0);

    // glitch shorter than half a bit
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk_50mhz);
    i_rx = 1'b1;
    repeat (2) @(negedge i_clk_50mhz);
    chk("glitch_busy", bus.o_busy, 1'b1);
    wait_idle("glitch", 40);
    chk("glitch_count", bus.o_count, 4'd0);
    chk("glitch_ferr", bus.o_frame_err, 1'b0);
    chk("glitch_ovr", bus.o_overrun, 1'b0);
    sb.push_back(8'hA3);
    send_byte(8'hA3, 0);
    wait_idle("a3", 50);
    pop_chk("a3");

    // frame error followed by a line break
    send_byte(8'h0F, 3);
    wait_idle("ferr", 50);
    chk("ferr_flag", bus.o_frame_err, 1'b1);
    chk("ferr_count", bus.o_count, 4'd0);
    sb.push_back(8'h12);
    send_byte(8'h12, 0);
    wait_idle("b12", 50);
    chk("ferr_sticky", bus.o_frame_err, 1'b1);
    pop_chk("b12");
    bus.i_clr_err = 1'b1;
    @(negedge i_clk_50mhz);
    bus.i_clr_err = 1'b0;
    chk("ferr_clr", bus.o_frame_err, 1'b0);

    // overrun: nine bytes into eight slots
    for (int i = 0; i < 9; i++) begin
      if (i < 8) sb.push_back(8'(i));
      send_byte(8'(i), 0);
    end
    wait_idle("ovr", 50);
    chk("ovr_count", bus.o_count, 4'd8);
    chk("ovr_flag", bus.o_overrun, 1'b1);
    for (int i = 0; i < 8; i++) pop_chk("ovr_pop");
    chk("ovr_drained", bus.o_valid, 1'b0);
    bus.i_clr_err = 1'b1;
    @(negedge i_clk_50mhz);
    bus.i_clr_err = 1'b0;
    chk("ovr_clr", bus.o_overrun, 1'b0);

    // push+pop on the same edge: empty, then one held
    send_pop_at_push("pp_empty", 8'h09, 1'b0);
    wait_idle("pp_empty", 50);
    chk("pp_empty_count", bus.o_count, 4'd1);
    send_pop_at_push("pp_one", 8'h0A, 1'b1);
    wait_idle("pp_one", 50);
    chk("pp_one_count", bus.o_count, 4'd1);
    pop_chk("pp_one_pop");
    chk("pp_one_count0", bus.o_count, 4'd0);

    // full plus simultaneous pop
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'h30 + 8'(i));
      send_byte(8'h30 + 8'(i), 0);
    end
    wait_idle("full", 50);
    chk("full_count", bus.o_count, 4'd8);
    send_pop_at_push("full_pp", 8'h77, 1'b1);
    wait_idle("full_pp", 50);
    chk("full_pp_ovr", bus.o_overrun, 1'b0);
    chk("full_pp_count", bus.o_count, 4'd8);
    for (int i = 0; i < 8; i++) pop_chk("full_pop");
    chk("full_drained", bus.o_count, 4'd0);

    // reset in the middle of a frame, with one byte already held
    send_byte(8'h99, 0);
    wait_idle("pre_rst", 50);
    chk("pre_rst_count", bus.o_count, 4'd1);
    fork
      send_byte(8'hC6, 0);
      begin
        repeat (CPB * 5 + CPB / 2) @(negedge i_clk_50mhz);
        chk("mid_busy", bus.o_busy, 1'b1);
        i_reset_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
      end
    join
    repeat (2) @(negedge i_clk_50mhz);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk_50mhz);
    chk_all_zero("post_rst");
    sb.push_back(8'h3C);
    send_byte(8'h3C, 0);
    wait_idle("b3c", 50);
    chk("b3c_count", bus.o_count, 4'd1);
    pop_chk("b3c");
    chk("b3c_count0", bus.o_count, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
